// File: rtl/sweep_scheduler.sv
// Calibration sequencer: sweeps the horizontal then vertical servo, records the pulse width at
// peak irradiance per axis, and parks each servo there before moving on.
module sweep_scheduler #(
    parameter int unsigned PW_MIN         = 5000,
    parameter int unsigned PW_MAX         = 25000,
    parameter int unsigned ADC_W          = 12,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned RECAL_CYCLES   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             auto,
    input  logic [ADC_W-1:0] light,
    input  logic             light_valid,
    input  logic [31:0]      pw_h,
    input  logic [31:0]      pw_v,
    output logic [1:0]       dir_h,
    output logic [1:0]       dir_v,
    output logic             en_h,
    output logic             en_v,
    output logic             es_h,
    output logic             es_v,
    output logic             mc_h,
    output logic             mc_v,
    output logic [31:0]      pwmax_h,
    output logic [31:0]      pwmax_v,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHSweep  = 3'd1,
        StHReturn = 3'd2,
        StHSettle = 3'd3,
        StVSweep  = 3'd4,
        StVReturn = 3'd5,
        StVSettle = 3'd6
    } state_e;

    localparam logic [1:0] DirStop = 2'b00;
    localparam logic [1:0] DirInc  = 2'b01;
    localparam logic [1:0] DirMax  = 2'b10;

    state_e           state_q, state_d;
    logic [ADC_W-1:0] best_q, best_d;
    logic [31:0]      pwmax_h_q, pwmax_h_d;
    logic [31:0]      pwmax_v_q, pwmax_v_d;
    logic [31:0]      phase_cnt_q, phase_cnt_d;
    logic [31:0]      idle_cnt_q, idle_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [1:0] dir_h_q, dir_h_d, dir_v_q, dir_v_d;
    logic       en_h_q, en_h_d, en_v_q, en_v_d;
    logic       es_h_q, es_h_d, es_v_q, es_v_d;
    logic       mc_h_q, mc_h_d, mc_v_q, mc_v_d;

    logic timeout;
    logic settle_done;
    logic recal;

    assign timeout     = (state_q != StIdle) && (phase_cnt_q == TIMEOUT_CYCLES - 1);
    assign settle_done = (phase_cnt_q == SETTLE_CYCLES - 1);
    assign recal       = auto && (idle_cnt_q == RECAL_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        best_d     = best_q;
        pwmax_h_d  = pwmax_h_q;
        pwmax_v_d  = pwmax_v_q;
        err_d      = err_q;
        done_d     = 1'b0;
        idle_cnt_d = 32'd0;

        // Abort outranks everything, then the watchdog, then normal sequencing.
        if (abort) begin
            state_d = StIdle;
        end else if (timeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (auto) idle_cnt_d = idle_cnt_q + 32'd1;
                    if (start || recal) begin
                        state_d    = StHSweep;
                        err_d      = 1'b0;
                        best_d     = '0;
                        pwmax_h_d  = 32'(PW_MIN);
                        idle_cnt_d = 32'd0;
                    end
                end
                StHSweep: begin
                    if (light_valid) begin
                        if (light > best_q) begin
                            best_d    = light;
                            pwmax_h_d = pw_h;
                        end
                        if (pw_h >= 32'(PW_MAX)) state_d = StHReturn;
                    end
                end
                StHReturn: begin
                    if (pw_h == pwmax_h_q) state_d = StHSettle;
                end
                StHSettle: begin
                    if (settle_done) begin
                        state_d   = StVSweep;
                        best_d    = '0;
                        pwmax_v_d = 32'(PW_MIN);
                    end
                end
                StVSweep: begin
                    if (light_valid) begin
                        if (light > best_q) begin
                            best_d    = light;
                            pwmax_v_d = pw_v;
                        end
                        if (pw_v >= 32'(PW_MAX)) state_d = StVReturn;
                    end
                end
                StVReturn: begin
                    if (pw_v == pwmax_v_q) state_d = StVSettle;
                end
                StVSettle: begin
                    if (settle_done) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_q == StIdle || state_d != state_q) begin
            phase_cnt_d = 32'd0;
        end else begin
            phase_cnt_d = phase_cnt_q + 32'd1;
        end

        busy_d = (state_d != StIdle);
    end

    // Servo controls are decoded from the current state, so they follow a transition by one cycle.
    always_comb begin
        dir_h_d = DirStop;
        dir_v_d = DirStop;
        en_h_d  = 1'b0;
        en_v_d  = 1'b0;
        es_h_d  = 1'b0;
        es_v_d  = 1'b0;
        mc_h_d  = 1'b0;
        mc_v_d  = 1'b0;
        unique case (state_q)
            StHSweep: begin
                dir_h_d = DirInc;
                en_h_d  = 1'b1;
                es_h_d  = 1'b1;
            end
            StHReturn, StHSettle: begin
                dir_h_d = DirMax;
                en_h_d  = 1'b1;
                mc_h_d  = 1'b1;
            end
            StVSweep: begin
                dir_v_d = DirInc;
                en_v_d  = 1'b1;
                es_v_d  = 1'b1;
            end
            StVReturn, StVSettle: begin
                dir_v_d = DirMax;
                en_v_d  = 1'b1;
                mc_v_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            best_q      <= '0;
            pwmax_h_q   <= 32'(PW_MIN);
            pwmax_v_q   <= 32'(PW_MIN);
            phase_cnt_q <= 32'd0;
            idle_cnt_q  <= 32'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dir_h_q     <= DirStop;
            dir_v_q     <= DirStop;
            en_h_q      <= 1'b0;
            en_v_q      <= 1'b0;
            es_h_q      <= 1'b0;
            es_v_q      <= 1'b0;
            mc_h_q      <= 1'b0;
            mc_v_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            pwmax_h_q   <= pwmax_h_d;
            pwmax_v_q   <= pwmax_v_d;
            phase_cnt_q <= phase_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dir_h_q     <= dir_h_d;
            dir_v_q     <= dir_v_d;
            en_h_q      <= en_h_d;
            en_v_q      <= en_v_d;
            es_h_q      <= es_h_d;
            es_v_q      <= es_v_d;
            mc_h_q      <= mc_h_d;
            mc_v_q      <= mc_v_d;
        end
    end

    assign dir_h   = dir_h_q;
    assign dir_v   = dir_v_q;
    assign en_h    = en_h_q;
    assign en_v    = en_v_q;
    assign es_h    = es_h_q;
    assign es_v    = es_v_q;
    assign mc_h    = mc_h_q;
    assign mc_v    = mc_v_q;
    assign pwmax_h = pwmax_h_q;
    assign pwmax_v = pwmax_v_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequences the horizontal and vertical servo PWM generators through a full calibration cycle.
- Order: horizontal sweep, horizontal return-to-max, vertical sweep, vertical return-to-max.
- During each sweep it pairs irradiance samples with the current servo pulse width and keeps the maximum.
- Sits between the top-level mode logic and the two PWM generator instances. It drives their DIR/EN/ES/MC controls and their pulseWidth_max inputs.

Parameters:
- PW_MIN, 5000: minimum pulse width (0 deg), in clock cycles.
- PW_MAX, 25000: maximum pulse width (180 deg); the sweep ends here.
- ADC_W, 12: irradiance sample width.
- SETTLE_CYCLES, 1000: hold time after the servo reaches the max position, before moving to the next phase.
- TIMEOUT_CYCLES, 2000000: per-phase watchdog limit.
- RECAL_CYCLES, 5000000: idle interval before an automatic restart when AUTO=1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin calibration; ignored unless in IDLE.
- ABORT  in  1  level; forces return to IDLE from any state.
- AUTO  in  1  enables periodic recalibration.
- LIGHT  in  ADC_W  irradiance sample.
- LIGHT_VALID  in  1  single-cycle qualifier for LIGHT.
- PW_H  in  32  current pulse width reported by the horizontal PWM generator.
- PW_V  in  32  current pulse width reported by the vertical PWM generator.
- DIR_H, DIR_V  out  2  direction: 00 stop, 01 increasing, 10 decreasing/max.
- EN_H, EN_V  out  1  PWM generator enables.
- ES_H, ES_V  out  1  sweep-start enables.
- MC_H, MC_V  out  1  max-position commands.
- PWMAX_H, PWMAX_V  out  32  pulse width at maximum irradiance, per axis.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a calibration completes.
- ERR  out  1  sticky watchdog-timeout flag; cleared on the next accepted START.
- STATE  out  3  state encoding, for debug LEDs.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; all DIR=00; all EN/ES/MC=0.
  - PWMAX_H=PWMAX_V=PW_MIN; best=0; BUSY=DONE=ERR=0; all counters=0.
- All outputs are registered. Control outputs change one cycle after the state transition.
- States and encoding: IDLE(0), H_SWEEP(1), H_RETURN(2), H_SETTLE(3), V_SWEEP(4), V_RETURN(5), V_SETTLE(6).
- IDLE:
  - Outputs: DIR=00, EN=0.
  - START=1 -> H_SWEEP. This clears ERR, sets best=0 and PWMAX_H=PW_MIN.
  - AUTO=1: an idle counter runs. When it reaches RECAL_CYCLES-1 it acts as START. The counter clears on leaving IDLE or when AUTO=0.
- x_SWEEP (x = H or V):
  - Outputs: DIR_x=01, EN_x=1, ES_x=1, MC_x=0. The other axis has EN=0 and DIR=00.
  - On each LIGHT_VALID: if LIGHT > best (strictly greater), then best<=LIGHT and PWMAX_x<=PW_x.
  - Ties keep the earlier (smaller) pulse width.
  - Sweep ends on the first LIGHT_VALID with PW_x >= PW_MAX. That sample is compared first, then the state moves to x_RETURN.
- x_RETURN:
  - Outputs: DIR_x=10, EN_x=1, MC_x=1, ES_x=0.
  - When PW_x == PWMAX_x -> x_SETTLE.
- x_SETTLE:
  - Outputs are held as in x_RETURN.
  - After SETTLE_CYCLES cycles:
    - H_SETTLE -> V_SWEEP, with best=0 and PWMAX_V=PW_MIN.
    - V_SETTLE -> IDLE, pulsing DONE for one cycle.
- Watchdog:
  - A phase counter clears on every state change.
  - If it reaches TIMEOUT_CYCLES in any non-IDLE state: ERR<=1 -> IDLE, and DONE is not pulsed.
  - PWMAX values are left as captured so far.
- ABORT=1 in any state -> IDLE on the next edge; no DONE. ABORT takes priority over START, timeout and settle completion.
- START while BUSY is ignored. START and AUTO expiry in the same cycle count as a single start.
- LIGHT_VALID outside the sweep states is ignored.
- Comparisons are unsigned. best is ADC_W bits wide. PW comparisons are 32-bit unsigned.
- RST_N deasserted mid-calibration: outputs go immediately to their reset values; calibration does not resume.

Test Plan:
- Reset then START; LIGHT_VALID each PW step 5000,9000,...,25000 with LIGHT=10,50,900,50,10,5 -> H_SWEEP captures PWMAX_H=13000; state goes to H_RETURN after the 25000 sample with DIR_H=10, MC_H=1.
- Continuing: PW_H driven to 13000 -> H_SETTLE; after 1000 cycles -> V_SWEEP with ES_V=1, DIR_V=01, EN_H=0; a full vertical pass then DONE pulses exactly one cycle and BUSY=0.
- Equal peaks LIGHT=700 at PW 9000 and 21000 -> PWMAX=9000 (first peak retained).
- ABORT asserted during V_RETURN -> IDLE next cycle, DIR_V=00, EN_V=0, DONE stays 0, PWMAX_H unchanged.
- PW_H frozen at 17000 in H_RETURN (target 13000), TIMEOUT_CYCLES=100 -> ERR=1 and IDLE after 100 cycles; a subsequent START clears ERR.
- AUTO=1, RECAL_CYCLES=50, idle after DONE -> H_SWEEP entered 50 cycles later; START pulses mid-sweep have no effect.
